pixel_clock_tx: RTL and testbench
=================================

Name: pixel_clock_tx

Overview:
- Transmit-side counterpart to the input pixel-clock x6 PLL and phase tracker.
- Runs on the 81.000 MHz x6 system clock and regenerates a 13.500 MHz pixel clock output.
- Launches buffered pixel words so they are stable around each regenerated pixel-clock rising edge.
- Sits between the video pipeline (valid/ready source) and the external video output pins.

Parameters:
- DATA_WIDTH, 8: pixel word width.
- FIFO_DEPTH, 4: input buffer depth. Must be a power of 2, at least 2.
- CLK_HIGH_PHASES, 3: number of x6 phases (starting at phase 0) for which pixelClockOut is high. Range 1..5.
- LAUNCH_PHASE, 3: phase during which a newly launched pixelDataOut first appears. Range 1..5.
- BLANK_VALUE, 0: word driven when idle, priming, or underflowing.

Ports:
- pixelClockX6  input  1  81.000 MHz system clock. All logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  request to stream.
- pixelData  input  DATA_WIDTH  word from the pipeline.
- pixelValid  input  1  pixelData is valid.
- pixelReady  output  1  buffer can accept a word. Transfer occurs when pixelValid && pixelReady.
- pixelClockOut  output  1  regenerated pixel clock, registered.
- pixelDataOut  output  DATA_WIDTH  launched pixel word, registered.
- pixelClockPhase  output  3  current phase counter value, 0..5.
- underflow  output  1  sticky: a launch found the FIFO empty while in RUN.
- underflowClear  input  1  clears underflow.
- fifoLevel  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset: takes priority over everything and is valid mid-operation.
  - Phase counter = 0, state = IDLE, FIFO emptied (level 0).
  - pixelClockOut = 0, pixelDataOut = BLANK_VALUE, underflow = 0, pixelReady = 1.
- Phase counter: free-running 0,1,2,3,4,5,0,… in every state. Wraps 5→0. Never takes values 6 or 7.
- FIFO:
  - pixelReady = (fifoLevel != FIFO_DEPTH), combinational from registered level.
  - Push when pixelValid && pixelReady; the word is written at that edge.
  - Pop only as specified under RUN.
  - Simultaneous push and pop leaves the level unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Data ordering is strictly FIFO.
- State machine:
  - IDLE: pixelClockOut = 0, pixelDataOut = BLANK_VALUE. enable = 1 → PRIME.
  - PRIME: clock held low. FIFO fills.
    - enable = 0 → IDLE.
    - At the edge where the phase wraps 5→0, if fifoLevel ≥ FIFO_DEPTH/2 → RUN.
    - pixelClockOut rises on that same edge, so the first high cycle has phase 0.
  - RUN:
    - pixelClockOut is registered so that it is 1 exactly while pixelClockPhase < CLK_HIGH_PHASES.
    - In the cycle where pixelClockPhase == LAUNCH_PHASE−1:
      - FIFO non-empty: pop; pixelDataOut takes the head word at that edge.
      - FIFO empty: pixelDataOut takes BLANK_VALUE and underflow is set.
      - Streaming continues in both cases; no return to PRIME.
    - enable = 0: the current period completes. At the 5→0 wrap edge → IDLE.
      - pixelClockOut is 0 from that edge.
      - pixelDataOut becomes BLANK_VALUE on the same edge.
      - FIFO contents are retained, not flushed.
  - Latency: a word pushed into an empty FIFO in RUN reaches pixelDataOut at the next launch edge. This is at most 6 cycles after the push edge.
- underflow:
  - Sets only in RUN.
  - underflowClear clears it.
  - Set and clear in the same cycle → set wins.
- Clock output: glitch-free, driven directly from a register. Exactly one rising edge per 6 cycles in RUN. Duty cycle = CLK_HIGH_PHASES/6.

Test Plan:
- Reset mid-RUN with 3 words queued → next cycle: fifoLevel = 0, pixelClockOut = 0, pixelDataOut = 0x00, underflow = 0, phase = 0, pixelReady = 1.
- enable = 1, push 0x11, 0x22 (level 2) → RUN entered at the next 5→0 wrap. pixelClockOut is high during phases 0–2 and low during 3–5. 0x11 appears at the phase-3 cycle, 0x22 six cycles later.
- Continuous pixelValid with a fast source → level saturates at 4 and pixelReady drops to 0. No word is lost or duplicated: out sequence = in sequence 0x00..0x3F over 64 pixels.
- In RUN, stop supplying words → at the first empty launch pixelDataOut = 0x00 and underflow = 1. underflow stays set after data resumes. underflowClear pulse → 0. Simultaneous set and clear → stays 1.
- enable dropped at phase 1 in RUN → clock completes the current period and goes low at the 5→0 edge. State returns to IDLE and residual FIFO words are retained (fifoLevel unchanged).
- Parameter sweep CLK_HIGH_PHASES = 1, 5 and LAUNCH_PHASE = 1, 5 → duty-cycle and launch timing match the formulas above. Phase never exceeds 5.

Source files
------------

// File: rtl/pixel_clock_tx.sv
// Transmit-side pixel clock regenerator: divides the x6 system clock down to a pixel clock
// and launches buffered pixel words so they are stable around each regenerated rising edge.
module pixel_clock_tx #(
    parameter int unsigned           DATA_WIDTH      = 8,
    parameter int unsigned           FIFO_DEPTH      = 4,
    parameter int unsigned           CLK_HIGH_PHASES = 3,
    parameter int unsigned           LAUNCH_PHASE    = 3,
    parameter logic [DATA_WIDTH-1:0] BLANK_VALUE     = '0
) (
    input  logic                          pixelClockX6,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DATA_WIDTH-1:0]         pixelData,
    input  logic                          pixelValid,
    output logic                          pixelReady,
    output logic                          pixelClockOut,
    output logic [DATA_WIDTH-1:0]         pixelDataOut,
    output logic [2:0]                    pixelClockPhase,
    output logic                          underflow,
    input  logic                          underflowClear,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    localparam logic [LvlW-1:0] LvlFull   = LvlW'(FIFO_DEPTH);
    localparam logic [LvlW-1:0] LvlHalf   = LvlW'(FIFO_DEPTH / 2);
    localparam logic [2:0]      PhaseLast = 3'd5;
    localparam logic [2:0]      HighPh    = 3'(CLK_HIGH_PHASES);
    localparam logic [2:0]      LaunchPh  = 3'(LAUNCH_PHASE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StRun
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              phase_q, phase_d;
    logic                    clk_q, clk_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    uf_q, uf_d;
    logic [PtrW-1:0]         wptr_q, wptr_d;
    logic [PtrW-1:0]         rptr_q, rptr_d;
    logic [LvlW-1:0]         level_q, level_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [FIFO_DEPTH];

    logic wrap;
    logic launch;
    logic push;
    logic pop;
    logic uf_set;

    assign pixelReady      = (level_q != LvlFull);
    assign pixelClockOut   = clk_q;
    assign pixelDataOut    = data_q;
    assign pixelClockPhase = phase_q;
    assign underflow       = uf_q;
    assign fifoLevel       = level_q;

    always_comb begin
        wrap    = (phase_q == PhaseLast);
        launch  = (phase_q == LaunchPh);
        phase_d = wrap ? 3'd0 : phase_q + 3'd1;
        push    = pixelValid && pixelReady;

        state_d = state_q;
        clk_d   = 1'b0;
        data_d  = data_q;
        pop     = 1'b0;
        uf_set  = 1'b0;

        unique case (state_q)
            StIdle: begin
                data_d = BLANK_VALUE;
                if (enable) begin
                    state_d = StPrime;
                end
            end
            StPrime: begin
                data_d = BLANK_VALUE;
                if (!enable) begin
                    state_d = StIdle;
                end else if (wrap && (level_q >= LvlHalf)) begin
                    // Rise together with the phase wrap so the first high cycle is phase 0.
                    state_d = StRun;
                    clk_d   = 1'b1;
                end
            end
            StRun: begin
                clk_d = (phase_d < HighPh);
                if (launch) begin
                    if (level_q != '0) begin
                        pop    = 1'b1;
                        data_d = mem_q[rptr_q];
                    end else begin
                        data_d = BLANK_VALUE;
                        uf_set = 1'b1;
                    end
                end
                // Stop only at a period boundary so the last clock pulse is never truncated.
                if (!enable && wrap) begin
                    state_d = StIdle;
                    clk_d   = 1'b0;
                    data_d  = BLANK_VALUE;
                end
            end
            default: begin
                state_d = StIdle;
                data_d  = BLANK_VALUE;
            end
        endcase

        uf_d = uf_set | (uf_q & ~underflowClear);
    end

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q] = pixelData;
            wptr_d        = wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge pixelClockX6) begin
        if (reset) begin
            state_q <= StIdle;
            phase_q <= 3'd0;
            clk_q   <= 1'b0;
            data_q  <= BLANK_VALUE;
            uf_q    <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            clk_q   <= clk_d;
            data_q  <= data_d;
            uf_q    <= uf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: the level and pointers alone define what is valid.
    always_ff @(posedge pixelClockX6) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_pixel_clock_tx.sv
// Directed bench for pixel_clock_tx: default instance plus two instances sweeping the
// clock-high and launch-phase parameters to their extremes.
module tb_pixel_clock_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] pixelData;
    logic       pixelValid;
    logic       underflowClear;

    logic       ready,   clk_out,   uf;
    logic       ready_a, clk_out_a, uf_a;
    logic       ready_b, clk_out_b, uf_b;
    logic [7:0] data_out, data_out_a, data_out_b;
    logic [2:0] phase, phase_a, phase_b;
    logic [2:0] level, level_a, level_b;

    int total = 0;
    int bad   = 0;
    int ph    = 0;

    always #5 clk = ~clk;

    pixel_clock_tx u_dut (
        .pixelClockX6   (clk),
        .reset          (reset),
        .enable         (enable),
        .pixelData      (pixelData),
        .pixelValid     (pixelValid),
        .pixelReady     (ready),
        .pixelClockOut  (clk_out),
        .pixelDataOut   (data_out),
        .pixelClockPhase(phase),
        .underflow      (uf),
        .underflowClear (underflowClear),
        .fifoLevel      (level)
    );

    pixel_clock_tx #(.CLK_HIGH_PHASES(1), .LAUNCH_PHASE(1)) u_dut_a (
        .pixelClockX6   (clk),
        .reset          (reset),
        .enable         (enable),
        .pixelData      (pixelData),
        .pixelValid     (pixelValid),
        .pixelReady     (ready_a),
        .pixelClockOut  (clk_out_a),
        .pixelDataOut   (data_out_a),
        .pixelClockPhase(phase_a),
        .underflow      (uf_a),
        .underflowClear (underflowClear),
        .fifoLevel      (level_a)
    );

    pixel_clock_tx #(.CLK_HIGH_PHASES(5), .LAUNCH_PHASE(5)) u_dut_b (
        .pixelClockX6   (clk),
        .reset          (reset),
        .enable         (enable),
        .pixelData      (pixelData),
        .pixelValid     (pixelValid),
        .pixelReady     (ready_b),
        .pixelClockOut  (clk_out_b),
        .pixelDataOut   (data_out_b),
        .pixelClockPhase(phase_b),
        .underflow      (uf_b),
        .underflowClear (underflowClear),
        .fifoLevel      (level_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs are changed and outputs sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        if (reset) ph = 0;
        else       ph = (ph == 5) ? 0 : ph + 1;
        @(negedge clk);
        check("phase",   phase,   ph);
        check("phase_a", phase_a, ph);
        check("phase_b", phase_b, ph);
    endtask

    task automatic goto_ph(input int p);
        for (int i = 0; i < 6 && ph != p; i++) step();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_level"}, level,    0);
        check({tag, "_clk"},   clk_out,  0);
        check({tag, "_data"},  data_out, 8'h00);
        check({tag, "_uf"},    uf,       0);
        check({tag, "_phase"}, phase,    0);
        check({tag, "_ready"}, ready,    1);
    endtask

    int         lvl, in_idx, out_idx, k, ka, kb;
    bit         push, launch, pop, start, run_m;
    logic [7:0] exp_d, da, db;
    logic [7:0] w2 [2];

    initial begin
        reset = 1'b1; enable = 1'b0; pixelValid = 1'b0; pixelData = 8'h00;
        underflowClear = 1'b0;
        @(negedge clk);
        step();
        check_reset("por");
        reset = 1'b0;

        // Prime with two words, then first RUN periods.
        enable = 1'b1; pixelValid = 1'b1; pixelData = 8'h11;
        step();
        pixelData = 8'h22;
        step();
        pixelValid = 1'b0;
        check("prime_level", level, 2);
        check("prime_clk", clk_out, 0);
        while (ph != 5) begin
            step();
            check("prime_clk_hold", clk_out, 0);
        end
        w2[0] = 8'h11; w2[1] = 8'h22; exp_d = 8'h00; k = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ph == 3) begin
                exp_d = (k < 2) ? w2[k] : 8'h00;
                k++;
            end
            check("run_clk", clk_out, ph < 3);
            check("run_data", data_out, exp_d);
        end
        check("run_level", level, 0);
        check("run_uf", uf, 0);

        // Underflow: set, sticky, clear, and set-beats-clear.
        goto_ph(3);
        check("uf_data", data_out, 8'h00);
        check("uf_set", uf, 1);
        pixelValid = 1'b1; pixelData = 8'h33;
        step();
        pixelValid = 1'b0;
        check("uf_push_level", level, 1);
        check("uf_sticky", uf, 1);
        goto_ph(3);
        check("uf_resume_data", data_out, 8'h33);
        check("uf_resume_sticky", uf, 1);
        check("uf_resume_level", level, 0);
        underflowClear = 1'b1;
        step();
        underflowClear = 1'b0;
        check("uf_cleared", uf, 0);
        goto_ph(2);
        underflowClear = 1'b1;
        step();
        underflowClear = 1'b0;
        check("uf_set_wins", uf, 1);
        check("uf_set_wins_data", data_out, 8'h00);

        // Enable dropped mid-period: period completes, FIFO retained.
        pixelValid = 1'b1; pixelData = 8'h44; step();
        pixelData = 8'h55; step();
        pixelData = 8'h66; step();
        pixelValid = 1'b0;
        check("drop_level", level, 3);
        step();
        enable = 1'b0;
        step();
        check("drop_clk_ph2", clk_out, 1);
        step();
        check("drop_clk_ph3", clk_out, 0);
        check("drop_data_ph3", data_out, 8'h44);
        check("drop_level_ph3", level, 2);
        step();
        step();
        step();
        check("idle_clk", clk_out, 0);
        check("idle_data", data_out, 8'h00);
        check("idle_level", level, 2);
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_hold_clk", clk_out, 0);
            check("idle_hold_level", level, 2);
        end

        // Refill to full, enter RUN, then reset with 3 words queued.
        goto_ph(1);
        enable = 1'b1; pixelValid = 1'b1; pixelData = 8'h77; step();
        pixelData = 8'h88; step();
        pixelValid = 1'b0;
        check("full_ready", ready, 0);
        check("full_level", level, 4);
        goto_ph(0);
        check("rerun_clk", clk_out, 1);
        goto_ph(3);
        check("rerun_data", data_out, 8'h55);
        check("rerun_level", level, 3);
        check("rerun_ready", ready, 1);
        goto_ph(0);
        check("prereset_clk", clk_out, 1);
        check("prereset_uf", uf, 1);
        reset = 1'b1;
        step();
        check_reset("midrun");
        reset = 1'b0;

        // Fast source: 64 words, level saturates, strict ordering.
        lvl = 0; in_idx = 0; out_idx = 0; exp_d = 8'h00; run_m = 1'b0;
        for (int i = 0; i < 460 && out_idx < 64; i++) begin
            pixelValid = (in_idx < 64);
            pixelData  = 8'(in_idx);
            check("ord_ready", ready, lvl != 4);
            push   = pixelValid && ready;
            launch = run_m && ph == 2;
            pop    = launch && lvl > 0;
            start  = !run_m && ph == 5 && lvl >= 2;
            step();
            lvl = lvl + (push ? 1 : 0) - (pop ? 1 : 0);
            if (push) in_idx++;
            if (launch) begin
                if (pop) begin
                    exp_d = 8'(out_idx);
                    out_idx++;
                end else begin
                    exp_d = 8'h00;
                end
            end
            if (start) run_m = 1'b1;
            check("ord_level", level, lvl);
            check("ord_data", data_out, exp_d);
            check("ord_clk", clk_out, run_m && ph < 3);
        end
        pixelValid = 1'b0;
        check("ord_in_count", in_idx, 64);
        check("ord_out_count", out_idx, 64);

        // Parameter extremes: high/launch phase 1 and 5.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("sw_ready_a", ready_a, 1);
        check("sw_ready_b", ready_b, 1);
        check("sw_uf_a", uf_a, 0);
        check("sw_uf_b", uf_b, 0);
        pixelValid = 1'b1; pixelData = 8'hA1; step();
        pixelData = 8'hA2; step();
        pixelValid = 1'b0;
        check("sw_level_a", level_a, 2);
        check("sw_level_b", level_b, 2);
        w2[0] = 8'hA1; w2[1] = 8'hA2;
        run_m = 1'b0; da = 8'h00; db = 8'h00; ka = 0; kb = 0;
        for (int i = 0; i < 16; i++) begin
            start = !run_m && ph == 5;
            step();
            if (start) run_m = 1'b1;
            if (run_m && ph == 1) begin
                da = (ka < 2) ? w2[ka] : 8'h00;
                ka++;
            end
            if (run_m && ph == 5) begin
                db = (kb < 2) ? w2[kb] : 8'h00;
                kb++;
            end
            check("sw_clk_a", clk_out_a, run_m && ph < 1);
            check("sw_clk_b", clk_out_b, run_m && ph < 5);
            check("sw_data_a", data_out_a, da);
            check("sw_data_b", data_out_b, db);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
